// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and the timing-bus layout carried between stages.
package vga_pkg;

  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CHAR_H    = 16;
  localparam int unsigned TEXT_COLS = 16;
  localparam int unsigned TEXT_ROWS = 16;
  localparam int unsigned HCNT_W    = 11;
  localparam int unsigned RGB_W     = 12;

  localparam int unsigned BOX_W = CHAR_W * TEXT_COLS;
  localparam int unsigned BOX_H = CHAR_H * TEXT_ROWS;

  typedef struct packed {
    logic [HCNT_W-1:0] hcount;
    logic [HCNT_W-1:0] vcount;
    logic              hsync;
    logic              vsync;
    logic              hblnk;
    logic              vblnk;
    logic [RGB_W-1:0]  rgb;
    logic              in_box;
    logic [2:0]        xbit;
  } timing_t;

endpackage

// File: rtl/delay.sv
// Fixed-latency shift register with synchronous active-high reset.
module delay #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DEL = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [CLK_DEL];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(CLK_DEL); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < int'(CLK_DEL); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_rect_char.sv
// Text-box overlay: addresses the char-map/font ROMs and mixes glyph pixels into RGB.
module draw_rect_char
  import vga_pkg::*;
#(
  parameter logic [10:0] XPOS         = 11'd100,
  parameter logic [10:0] YPOS         = 11'd50,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  // Unsigned wrap makes positions left of / above the box fall outside it.
  logic [10:0] x_rel, y_rel;
  logic        in_box;
  assign x_rel  = hcount_in - XPOS;
  assign y_rel  = vcount_in - YPOS;
  assign in_box = (x_rel < 11'(BOX_W)) && (y_rel < 11'(BOX_H));

  logic [7:0] char_xy_d;
  logic [3:0] char_line_d;
  assign char_xy_d   = in_box ? {y_rel[7:4], x_rel[6:3]} : 8'h00;
  assign char_line_d = in_box ? y_rel[3:0] : 4'h0;

  always_ff @(posedge pclk) begin
    if (rst) begin
      char_xy   <= 8'h00;
      char_line <= 4'h0;
    end else begin
      char_xy   <= char_xy_d;
      char_line <= char_line_d;
    end
  end

  timing_t bus_in, bus_d2;
  always_comb begin
    bus_in        = '0;
    bus_in.hcount = hcount_in;
    bus_in.vcount = vcount_in;
    bus_in.hsync  = hsync_in;
    bus_in.vsync  = vsync_in;
    bus_in.hblnk  = hblnk_in;
    bus_in.vblnk  = vblnk_in;
    bus_in.rgb    = rgb_in;
    bus_in.in_box = in_box;
    bus_in.xbit   = x_rel[2:0];
  end

  // Two stages so the font ROM's registered char_pixels lines up with bus_d2.
  delay #(
    .WIDTH  ($bits(timing_t)),
    .CLK_DEL(2)
  ) u_delay (
    .clk_i (pclk),
    .rst_i (rst),
    .din_i (bus_in),
    .dout_o(bus_d2)
  );

  logic        glyph_bit;
  logic [11:0] rgb_d;
  assign glyph_bit = char_pixels[3'd7 - bus_d2.xbit];

  always_comb begin
    rgb_d = bus_d2.rgb;
    if (bus_d2.hblnk || bus_d2.vblnk) begin
      rgb_d = 12'h000;
    end else if (bus_d2.in_box && glyph_bit) begin
      rgb_d = LETTER_COLOR;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_d2.hcount;
      vcount_out <= bus_d2.vcount;
      hsync_out  <= bus_d2.hsync;
      vsync_out  <= bus_d2.vsync;
      hblnk_out  <= bus_d2.hblnk;
      vblnk_out  <= bus_d2.vblnk;
      rgb_out    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_rect_char.sv
// Directed bench for draw_rect_char with default XPOS=100, YPOS=50.
module tb_draw_rect_char;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  draw_rect_char dut (
    .pclk       (pclk),
    .rst        (rst),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .char_pixels(char_pixels),
    .char_xy    (char_xy),
    .char_line  (char_line),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic [11:0] c,
                       input logic hb, input logic vb);
    hcount_in = h;
    vcount_in = v;
    rgb_in    = c;
    hblnk_in  = hb;
    vblnk_in  = vb;
  endtask

  initial begin
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    char_pixels = 8'h00;
    drive(11'd150, 11'd60, 12'h777, 1'b1, 1'b1);
    tick();
    tick();
    check("rst_xy", 32'(char_xy), 32'h00);
    check("rst_line", 32'(char_line), 32'h0);
    check("rst_rgb", 32'(rgb_out), 32'h000);
    check("rst_hcnt", 32'(hcount_out), 32'd0);
    check("rst_hsync", 32'(hsync_out), 32'd0);
    check("rst_vblnk", 32'(vblnk_out), 32'd0);

    rst = 1'b0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;

    // Address generation, one clock after the inputs.
    drive(11'd100, 11'd50, 12'h000, 1'b0, 1'b0);
    tick();
    check("xy_origin", 32'(char_xy), 32'h00);
    check("line_origin", 32'(char_line), 32'h0);
    drive(11'd129, 11'd89, 12'h000, 1'b0, 1'b0);  // x_rel=29, y_rel=39
    tick();
    check("xy_mid", 32'(char_xy), 32'h23);
    check("line_mid", 32'(char_line), 32'h7);
    drive(11'd227, 11'd305, 12'h000, 1'b0, 1'b0);
    tick();
    check("xy_corner", 32'(char_xy), 32'hFF);
    check("line_corner", 32'(char_line), 32'hF);
    drive(11'd228, 11'd305, 12'h000, 1'b0, 1'b0);
    tick();
    check("xy_right_out", 32'(char_xy), 32'h00);
    drive(11'd227, 11'd306, 12'h000, 1'b0, 1'b0);
    tick();
    check("xy_below_out", 32'(char_xy), 32'h00);
    check("line_below_out", 32'(char_line), 32'h0);

    // Glyph overlay, xbit=0.
    drive(11'd100, 11'd50, 12'h123, 1'b0, 1'b0);
    char_pixels = 8'h00;
    tick();
    tick();
    char_pixels = 8'h80;
    tick();
    check("glyph_msb_on", 32'(rgb_out), 32'hFFF);
    check("glyph_hcnt", 32'(hcount_out), 32'd100);
    char_pixels = 8'h7F;
    tick();
    check("glyph_msb_off", 32'(rgb_out), 32'h123);

    // xbit=5 selects char_pixels[2].
    drive(11'd105, 11'd50, 12'h246, 1'b0, 1'b0);
    char_pixels = 8'h04;
    tick();
    tick();
    tick();
    check("glyph_b5_on", 32'(rgb_out), 32'hFFF);
    char_pixels = 8'h08;
    tick();
    check("glyph_b5_off", 32'(rgb_out), 32'h246);

    // Outside the box the glyph is ignored; timing passes through.
    drive(11'd99, 11'd60, 12'hABC, 1'b0, 1'b0);
    hsync_in = 1'b1;
    char_pixels = 8'hFF;
    tick();
    tick();
    tick();
    check("outside_rgb", 32'(rgb_out), 32'hABC);
    check("outside_hcnt", 32'(hcount_out), 32'd99);
    check("outside_vcnt", 32'(vcount_out), 32'd60);
    check("outside_hsync", 32'(hsync_out), 32'd1);
    check("outside_vsync", 32'(vsync_out), 32'd0);
    hsync_in = 1'b0;

    // Blanking forces black inside the box.
    drive(11'd110, 11'd60, 12'h555, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    check("hblnk_rgb", 32'(rgb_out), 32'h000);
    check("hblnk_out", 32'(hblnk_out), 32'd1);
    drive(11'd110, 11'd60, 12'h555, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    check("vblnk_rgb", 32'(rgb_out), 32'h000);
    check("vblnk_out", 32'(vblnk_out), 32'd1);

    // Exact 3-clock latency on a changing stream.
    drive(11'd300, 11'd10, 12'h111, 1'b0, 1'b0);
    tick();
    drive(11'd301, 11'd11, 12'h222, 1'b0, 1'b0);
    tick();
    drive(11'd302, 11'd12, 12'h333, 1'b0, 1'b0);
    tick();
    check("lat_hcnt0", 32'(hcount_out), 32'd300);
    check("lat_rgb0", 32'(rgb_out), 32'h111);
    tick();
    check("lat_hcnt1", 32'(hcount_out), 32'd301);
    check("lat_vcnt1", 32'(vcount_out), 32'd11);

    // Mid-line reset flushes everything.
    drive(11'd227, 11'd305, 12'h321, 1'b0, 1'b0);
    char_pixels = 8'h00;
    hsync_in = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mrst_xy", 32'(char_xy), 32'h00);
    check("mrst_line", 32'(char_line), 32'h0);
    check("mrst_hcnt", 32'(hcount_out), 32'd0);
    check("mrst_rgb", 32'(rgb_out), 32'h000);
    check("mrst_hsync", 32'(hsync_out), 32'd0);
    rst = 1'b0;
    tick();
    check("rel_xy", 32'(char_xy), 32'hFF);
    tick();
    check("rel_hcnt_flushed", 32'(hcount_out), 32'd0);
    tick();
    check("rel_hcnt", 32'(hcount_out), 32'd227);
    check("rel_rgb", 32'(rgb_out), 32'h321);
    check("rel_hsync", 32'(hsync_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
